// File: rtl/mem_slot_arbiter_pkg.sv
// Shared constants for the memory slot arbiter: requester indices, one-hot grants, TS/DMA pointer.
// Pure definitions, no logic.
package mem_slot_arbiter_pkg;

  localparam int RQ_VID = 0;
  localparam int RQ_CPU = 1;
  localparam int RQ_TS  = 2;
  localparam int RQ_DMA = 3;

  localparam logic [3:0] GNT_NONE = 4'b0000;
  localparam logic [3:0] GNT_VID  = 4'b0001;
  localparam logic [3:0] GNT_CPU  = 4'b0010;
  localparam logic [3:0] GNT_TS   = 4'b0100;
  localparam logic [3:0] GNT_DMA  = 4'b1000;

  localparam int STARVE_DEFAULT = 8;

  // Round-robin pointer between the two low-priority engines.
  typedef enum logic {
    RR_TS  = 1'b0,
    RR_DMA = 1'b1
  } rr_t;

endpackage

// File: rtl/slot_prio_pick.sv
// Combinational slot winner: video > starved DMA > CPU > TS/DMA round-robin, one-hot result.
// Zero latency; no backpressure (pure function of its inputs).
module slot_prio_pick
  import mem_slot_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic       rr,
  input  logic       starve,
  output logic [3:0] win
);

  always_comb begin
    win = GNT_NONE;
    if (req[RQ_VID]) begin
      win = GNT_VID;
    end else if (req[RQ_DMA] && starve) begin
      win = GNT_DMA;
    end else if (req[RQ_CPU]) begin
      win = GNT_CPU;
    end else if (req[RQ_TS] && (rr == RR_TS || !req[RQ_DMA])) begin
      // TS takes the slot on its turn, or whenever DMA is not asking.
      win = GNT_TS;
    end else if (req[RQ_DMA]) begin
      win = GNT_DMA;
    end
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Shares one memory bus among video/CPU/TS/DMA in 4-clock slots decided on each c3 edge.
// Latency: grant/bus visible 1 clk after c3, ack 4 clks later; no backpressure, losers keep req high.
module mem_slot_arbiter
  import mem_slot_arbiter_pkg::*;
#(
  parameter int AW     = 21,
  parameter int DW     = 16,
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0,
  input  logic          c3,
  input  logic [3:0]    req,
  input  logic [AW-1:0] addr_vid,
  input  logic [AW-1:0] addr_cpu,
  input  logic [AW-1:0] addr_ts,
  input  logic [AW-1:0] addr_dma,
  input  logic          we_cpu,
  input  logic          we_dma,
  input  logic [DW-1:0] wdata_cpu,
  input  logic [DW-1:0] wdata_dma,
  output logic [3:0]    grant,
  output logic [3:0]    ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata
);

  rr_t           rr_q;
  rr_t           rr_d;
  logic [3:0]    starve_q;
  logic [3:0]    starve_d;
  logic          starve;
  logic [3:0]    win;
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic [DW-1:0] wdata_d;
  logic [3:0]    grant_q;

  assign starve = (starve_q >= 4'(STARVE));

  slot_prio_pick u_pick (
    .req    (req),
    .rr     (rr_q),
    .starve (starve),
    .win    (win)
  );

  // Pointer and starvation bookkeeping, committed only on arbitration edges.
  always_comb begin
    rr_d     = rr_q;
    starve_d = starve_q;
    if (win == GNT_TS) begin
      rr_d = RR_DMA;
    end else if (win == GNT_DMA) begin
      rr_d = RR_TS;
    end
    if (!req[RQ_DMA] || win == GNT_DMA) begin
      starve_d = '0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Read-only requesters and idle slots keep the last write data; idle keeps the address too.
  always_comb begin
    addr_d  = mem_addr;
    we_d    = 1'b0;
    wdata_d = mem_wdata;
    case (win)
      GNT_VID: addr_d = addr_vid;
      GNT_CPU: begin
        addr_d  = addr_cpu;
        we_d    = we_cpu;
        wdata_d = wdata_cpu;
      end
      GNT_TS:  addr_d = addr_ts;
      GNT_DMA: begin
        addr_d  = addr_dma;
        we_d    = we_dma;
        wdata_d = wdata_dma;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= GNT_NONE;
      ack       <= GNT_NONE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rr_q      <= RR_TS;
      starve_q  <= '0;
    end else begin
      ack <= GNT_NONE;
      if (c3) begin
        ack       <= grant;
        grant     <= win;
        mem_req   <= |win;
        mem_addr  <= addr_d;
        mem_we    <= we_d;
        mem_wdata <= wdata_d;
        rr_q      <= rr_d;
        starve_q  <= starve_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= GNT_NONE;
    end else begin
      grant_q <= grant;
    end
  end

  // Slot ownership may only change on the c0 clock that follows an arbitration edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (grant != grant_q) begin
        assert (c0);
      end
      assert ($onehot0(grant));
      assert ($onehot0(ack));
    end
  end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed + randomized bench for mem_slot_arbiter against a slot-level reference model.
// Each step advances one clock; every clock compares all DUT outputs with the model.
module tb_mem_slot_arbiter;

  localparam int AW     = 21;
  localparam int DW     = 16;
  localparam int STARVE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c0  = 1'b1;
  logic          c3  = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [AW-1:0] addr_vid = '0, addr_cpu = '0, addr_ts = '0, addr_dma = '0;
  logic          we_cpu = 1'b0, we_dma = 1'b0;
  logic [DW-1:0] wdata_cpu = '0, wdata_dma = '0;
  logic [3:0]    grant, ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int n_chk  = 0;
  int n_pass = 0;
  int ph     = 0;
  bit stall  = 1'b0;

  // Reference model state: slot owner as an index, TS/DMA turn, DMA lost-slot count.
  logic [3:0]    m_grant, m_ack;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_dma_turn;
  int            m_lost;

  always #5 clk = ~clk;

  mem_slot_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .c0        (c0),
    .c3        (c3),
    .req       (req),
    .addr_vid  (addr_vid),
    .addr_cpu  (addr_cpu),
    .addr_ts   (addr_ts),
    .addr_dma  (addr_dma),
    .we_cpu    (we_cpu),
    .we_dma    (we_dma),
    .wdata_cpu (wdata_cpu),
    .wdata_dma (wdata_dma),
    .grant     (grant),
    .ack       (ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_grant    = 4'b0000;
    m_ack      = 4'b0000;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_dma_turn = 1'b0;
    m_lost     = 0;
  endtask

  // Index of the slot winner (0 vid, 1 cpu, 2 ts, 3 dma) or -1 for an idle slot.
  function automatic int pick_winner();
    if (req[0]) return 0;
    if (req[3] && m_lost >= STARVE) return 3;
    if (req[1]) return 1;
    if (req[2] && req[3]) return m_dma_turn ? 3 : 2;
    if (req[2]) return 2;
    if (req[3]) return 3;
    return -1;
  endfunction

  // Applies the effect of the coming clock edge using the inputs as they stand now.
  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    m_ack = 4'b0000;
    if (!c3) return;
    m_ack   = m_grant;
    w       = pick_winner();
    m_grant = (w < 0) ? 4'b0000 : 4'(1 << w);
    m_req   = (w >= 0);
    m_we    = 1'b0;
    case (w)
      0: m_addr = addr_vid;
      1: begin m_addr = addr_cpu; m_we = we_cpu; m_wdata = wdata_cpu; end
      2: m_addr = addr_ts;
      3: begin m_addr = addr_dma; m_we = we_dma; m_wdata = wdata_dma; end
      default: ;
    endcase
    if (w == 2) m_dma_turn = 1'b1;
    if (w == 3) m_dma_turn = 1'b0;
    if (!req[3] || w == 3) m_lost = 0;
    else if (m_lost < 15) m_lost++;
  endtask

  task automatic model_check();
    chk("grant", grant, m_grant);
    chk("ack", ack, m_ack);
    chk("mem_req", mem_req, m_req);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_we", mem_we, m_we);
    chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (!stall) ph = (ph + 1) % 4;
    c0 = (ph == 0);
    c3 = (ph == 3);
    model_check();
  endtask

  // Advance until the next clock edge is an arbitration edge.
  task automatic to_arb();
    for (int i = 0; i < 8 && !c3; i++) step();
  endtask

  initial begin
    model_reset();
    step();
    step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // CPU alone, held through its ack edge so it also wins the following slot.
    req = 4'b0010; addr_cpu = 21'h12345; we_cpu = 1'b1; wdata_cpu = 16'hBEEF;
    to_arb();
    step();
    chk("cpu_grant", grant, 4'b0010);
    chk("cpu_addr", mem_addr, 21'h12345);
    chk("cpu_we", mem_we, 1'b1);
    chk("cpu_wdata", mem_wdata, 16'hBEEF);
    step(); step();
    chk("cpu_ack_early", ack, 4'b0000);
    step(); step();
    chk("cpu_ack", ack, 4'b0010);
    req = 4'b0000;
    step();
    chk("cpu_ack_one_clk", ack, 4'b0000);

    // Video and CPU together: video first, CPU next slot, acks 4 clocks apart.
    req = 4'b0011; addr_vid = 21'h00ABC;
    to_arb();
    step();
    chk("vc_grant_vid", grant, 4'b0001);
    chk("vc_we_vid", mem_we, 1'b0);
    req = 4'b0010;
    step(); step(); step(); step();
    chk("vc_ack_vid", ack, 4'b0001);
    chk("vc_grant_cpu", grant, 4'b0010);
    req = 4'b0000;
    step(); step(); step(); step();
    chk("vc_ack_cpu", ack, 4'b0010);

    // TS and DMA held: strict alternation starting with TS.
    req = 4'b1100; we_dma = 1'b1; wdata_dma = 16'h5A5A; addr_dma = 21'h1F000; addr_ts = 21'h00777;
    to_arb();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_grant", grant, (i % 2 == 0) ? 4'b0100 : 4'b1000);
      step(); step(); step();
    end

    // CPU and DMA held: STARVE CPU slots, one DMA slot, then CPU again.
    req = 4'b1010;
    for (int i = 0; i < STARVE + 2; i++) begin
      step();
      chk("starve_grant", grant, (i == STARVE) ? 4'b1000 : 4'b0010);
      step(); step(); step();
    end
    req = 4'b0000;
    step(); step(); step(); step();

    // Reset in mid-slot: outputs drop at once, no ack for the aborted slot.
    req = 4'b0010; we_cpu = 1'b1;
    to_arb();
    step();
    chk("mid_rst_pre_grant", grant, 4'b0010);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_mem_we", mem_we, 1'b0);
    model_reset();
    #1;
    rst = 1'b0;
    to_arb();
    step();
    chk("mid_rst_no_ack", ack, 4'b0000);
    chk("mid_rst_regrant", grant, 4'b0010);
    req = 4'b0000;
    step(); step(); step(); step();

    // TS request withdrawn before the arbitration edge.
    req = 4'b0100;
    step();
    req = 4'b0000;
    to_arb();
    step();
    chk("blip_grant", grant, 4'b0000);
    chk("blip_mem_req", mem_req, 1'b0);
    step(); step(); step(); step();
    chk("blip_no_ack", ack, 4'b0000);

    // Phase strobes stop: slot held, no ack until c3 returns.
    req = 4'b0100;
    to_arb();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("stall_grant", grant, 4'b0100);
    chk("stall_ack", ack, 4'b0000);
    stall = 1'b0;
    req = 4'b0000;
    to_arb();
    step();
    chk("stall_ack_after", ack, 4'b0100);

    // Randomized traffic: requests held for random stretches, bus fields change every clock.
    for (int hold = 0, i = 0; i < 1600; i++) begin
      if (hold == 0) begin
        req[3:1] = 3'($urandom_range(0, 7));
        req[0]   = ($urandom_range(0, 4) == 0);
        hold     = $urandom_range(1, 48);
      end
      hold--;
      addr_vid  = AW'($urandom);
      addr_cpu  = AW'($urandom);
      addr_ts   = AW'($urandom);
      addr_dma  = AW'($urandom);
      we_cpu    = 1'($urandom);
      we_dma    = 1'($urandom);
      wdata_cpu = DW'($urandom);
      wdata_dma = DW'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
